// File: rtl/mha_seq_ctrl_if.sv
// Control/status bundle between the multi-head attention sequencer and its surroundings.
// The master side issues start/out_ready; the slave side (the sequencer) reports progress.
interface mha_seq_ctrl_if #(
  parameter int NUM_HEADS = 4,
  parameter int K_TILES   = 4,
  parameter int SA_DIM    = 4
) ();
  localparam int AW = (K_TILES * SA_DIM > 1) ? $clog2(K_TILES * SA_DIM) : 1;
  localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;

  logic          start;
  logic          out_ready;
  logic          busy;
  logic          sa_clear;
  logic          feed_en;
  logic [AW-1:0] rd_addr;
  logic [HW-1:0] head_idx;
  logic          out_valid;
  logic          done;

  modport master (
    output start, out_ready,
    input  busy, sa_clear, feed_en, rd_addr, head_idx, out_valid, done
  );

  modport slave (
    input  start, out_ready,
    output busy, sa_clear, feed_en, rd_addr, head_idx, out_valid, done
  );
endinterface

// File: rtl/mha_seq_ctrl.sv
// Multi-head attention sequencer: per head, clears the systolic array, feeds operand tiles,
// flushes the skewed partial sums and drains the accumulator row before moving to the next head.
module mha_seq_ctrl #(
  parameter int NUM_HEADS = 4,
  parameter int K_TILES   = 4,
  parameter int SA_DIM    = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mha_seq_ctrl_if.slave  bus_if
);
  localparam int FEED_LEN  = K_TILES * SA_DIM;
  localparam int FLUSH_LEN = 2 * SA_DIM - 2;
  localparam int AW = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;
  localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(FEED_LEN - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
  localparam logic [HW-1:0] LAST_HEAD  = HW'(NUM_HEADS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [HW-1:0] head_q, head_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          busy_q, busy_d;
  logic          sa_clear_q, sa_clear_d;
  logic          feed_en_q, feed_en_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    head_d    = head_q;
    flush_d   = flush_q;

    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          state_d   = S_CLEAR;
          head_d    = '0;
          rd_addr_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
      end
      S_FEED: begin
        // rd_addr doubles as the feed counter; it stops at the last tile row and holds through FLUSH.
        if (rd_addr_q == LAST_ADDR) begin
          flush_d = '0;
          if (FLUSH_LEN == 0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      S_FLUSH: begin
        if (flush_q == LAST_FLUSH) begin
          state_d = S_DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (bus_if.out_ready) begin
          if (head_q == LAST_HEAD) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_CLEAR;
            head_d    = head_q + HW'(1);
            rd_addr_d = '0;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        head_d    = '0;
        rd_addr_d = '0;
      end
      default: begin
        state_d   = S_IDLE;
        head_d    = '0;
        rd_addr_d = '0;
        flush_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they are flops aligned with state_q.
    busy_d      = (state_d != S_IDLE);
    sa_clear_d  = (state_d == S_CLEAR);
    feed_en_d   = (state_d == S_FEED);
    out_valid_d = (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      head_q      <= '0;
      flush_q     <= '0;
      busy_q      <= 1'b0;
      sa_clear_q  <= 1'b0;
      feed_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      head_q      <= head_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      sa_clear_q  <= sa_clear_d;
      feed_en_q   <= feed_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus_if.busy      = busy_q;
  assign bus_if.sa_clear  = sa_clear_q;
  assign bus_if.feed_en   = feed_en_q;
  assign bus_if.rd_addr   = rd_addr_q;
  assign bus_if.head_idx  = head_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.done      = done_q;
endmodule

// File: tb/tb_mha_seq_ctrl.sv
// Directed bench for mha_seq_ctrl: nominal pass, drain stall, ignored starts, mid-pass reset,
// and a one-head/one-tile configuration; handshakes and done pulses are scoreboarded by cycle.
module tb_mha_seq_ctrl;
  localparam int NH = 4;
  localparam int KT = 4;
  localparam int SA = 4;
  localparam int HEAD_CYC = 1 + KT * SA + 2 * SA - 2 + 1;

  typedef struct {
    bit is_done;
    int head;
    int cycle;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   base  = 0;
  exp_t sb[$];

  mha_seq_ctrl_if #(.NUM_HEADS(NH), .K_TILES(KT), .SA_DIM(SA)) dif ();
  mha_seq_ctrl_if #(.NUM_HEADS(1), .K_TILES(1), .SA_DIM(SA)) dif2 ();

  mha_seq_ctrl #(.NUM_HEADS(NH), .K_TILES(KT), .SA_DIM(SA)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_if  (dif)
  );

  mha_seq_ctrl #(.NUM_HEADS(1), .K_TILES(1), .SA_DIM(SA)) dut2 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_if  (dif2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input int b, input int stall_head, input int stall);
    exp_t e;
    for (int h = 0; h < NH; h++) begin
      e.is_done = 1'b0;
      e.head    = h;
      e.cycle   = b + HEAD_CYC * (h + 1) + ((h >= stall_head) ? stall : 0);
      sb.push_back(e);
    end
    e.is_done = 1'b1;
    e.head    = 0;
    e.cycle   = b + HEAD_CYC * NH + 1 + stall;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      step();
      if (dif.done) break;
    end
    chk(tag, dif.done, 1);
  endtask

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("exclusive", (int'(dif.sa_clear) + int'(dif.feed_en) + int'(dif.out_valid) + int'(dif.done)) <= 1, 1);
      chk("rd_addr_max", dif.rd_addr <= (KT * SA - 1), 1);
      chk("head_max", dif.head_idx <= (NH - 1), 1);
      if (dif.out_valid && dif.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_handshake", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("hs_kind", 0, e.is_done);
          chk("hs_head", dif.head_idx, e.head);
          chk("hs_cycle", cyc, e.cycle);
        end
      end
      if (dif.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 1, e.is_done);
          chk("done_cycle", cyc, e.cycle);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start      = 1'b0;
    dif.out_ready  = 1'b1;
    dif2.start     = 1'b0;
    dif2.out_ready = 1'b1;

    // Reset values while reset is held
    #3;
    chk("rst_busy", dif.busy, 0);
    chk("rst_sa_clear", dif.sa_clear, 0);
    chk("rst_feed_en", dif.feed_en, 0);
    chk("rst_out_valid", dif.out_valid, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_rd_addr", dif.rd_addr, 0);
    chk("rst_head_idx", dif.head_idx, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle_busy", dif.busy, 0);

    // Nominal pass
    base = cyc;
    dif.start = 1'b1;
    push_pass(base, NH, 0);
    step();
    dif.start = 1'b0;
    chk("a_sa_clear", dif.sa_clear, 1);
    chk("a_busy", dif.busy, 1);
    chk("a_head0", dif.head_idx, 0);
    for (int i = 0; i < KT * SA; i++) begin
      step();
      chk("a_feed_en", dif.feed_en, 1);
      chk("a_rd_addr", dif.rd_addr, i);
    end
    step();
    chk("a_flush_feed_en", dif.feed_en, 0);
    chk("a_flush_rd_addr", dif.rd_addr, KT * SA - 1);
    while (cyc < base + HEAD_CYC) step();
    chk("a_out_valid0", dif.out_valid, 1);
    chk("a_out_head0", dif.head_idx, 0);
    wait_done("a_done_seen");
    chk("a_done_cycle", cyc - base, 97);
    step();
    chk("a_busy_after", dif.busy, 0);

    // Drain stall of 5 cycles on head 2
    step();
    base = cyc;
    dif.start = 1'b1;
    push_pass(base, 2, 5);
    step();
    dif.start = 1'b0;
    while (cyc < base + 3 * HEAD_CYC) step();
    chk("b_out_valid", dif.out_valid, 1);
    chk("b_head", dif.head_idx, 2);
    dif.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("b_hold_valid", dif.out_valid, 1);
      chk("b_hold_head", dif.head_idx, 2);
    end
    dif.out_ready = 1'b1;
    wait_done("b_done_seen");
    chk("b_done_cycle", cyc - base, 102);

    // Starts during FEED and DONE are ignored; start right after done is taken
    step();
    step();
    base = cyc;
    dif.start = 1'b1;
    push_pass(base, NH, 0);
    step();
    dif.start = 1'b0;
    while (cyc < base + HEAD_CYC + 6) step();
    chk("c_in_feed", dif.feed_en, 1);
    dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    chk("c_head1", dif.head_idx, 1);
    while (cyc < base + 97) step();
    chk("c_done", dif.done, 1);
    dif.start = 1'b1;
    step();
    chk("c_idle_after_done", dif.busy, 0);
    base = cyc;
    push_pass(base, NH, 0);
    step();
    dif.start = 1'b0;
    chk("c_restart_clear", dif.sa_clear, 1);
    chk("c_restart_head", dif.head_idx, 0);
    wait_done("c_done2_seen");
    chk("c_done2_cycle", cyc - base, 97);

    // Asynchronous reset during FLUSH of head 3
    step();
    base = cyc;
    dif.start = 1'b1;
    push_pass(base, NH, 0);
    step();
    dif.start = 1'b0;
    while (cyc < base + 3 * HEAD_CYC + 19) step();
    chk("d_in_flush", dif.feed_en, 0);
    chk("d_busy", dif.busy, 1);
    chk("d_head3", dif.head_idx, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("d_rst_busy", dif.busy, 0);
    chk("d_rst_head", dif.head_idx, 0);
    chk("d_rst_rd_addr", dif.rd_addr, 0);
    chk("d_rst_valid", dif.out_valid, 0);
    chk("d_rst_done", dif.done, 0);
    sb.delete();
    step();
    step();
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("d_stay_idle", dif.busy, 0);
    end
    base = cyc;
    dif.start = 1'b1;
    push_pass(base, NH, 0);
    step();
    dif.start = 1'b0;
    wait_done("d_done_seen");
    chk("d_done_cycle", cyc - base, 97);

    // One head, one tile: FEED 4, FLUSH 6, out_valid at 12, done at 13
    step();
    base = cyc;
    dif2.start = 1'b1;
    step();
    dif2.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk("s_sa_clear", dif2.sa_clear, (c == 1));
      chk("s_feed_en", dif2.feed_en, (c >= 2 && c <= 5));
      chk("s_out_valid", dif2.out_valid, (c == 12));
      chk("s_done", dif2.done, (c == 13));
      if (c >= 2 && c <= 5) chk("s_rd_addr", dif2.rd_addr, c - 2);
      step();
    end
    chk("s_idle", dif2.busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mha_seq_ctrl.md
MHA_SEQ_CTRL -- requirements
Module: mha_seq_ctrl

Interface
REQ-001 Parameter NUM_HEADS, default 4: number of attention heads sequenced per start.
REQ-002 Parameter K_TILES, default 4: number of inner-dimension tiles per head.
REQ-003 Parameter SA_DIM, default 4: systolic array edge, in PEs.
REQ-004 clk  input  1: single clock; all state updates occur on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: request one full multi-head pass; sampled only in IDLE.
REQ-007 out_ready  input  1: downstream accepts the drained accumulator row.
REQ-008 busy  output  1: high in every state except IDLE.
REQ-009 sa_clear  output  1: clear systolic-array accumulators.
REQ-010 feed_en  output  1: drive operand skew buffers into the array this cycle.
REQ-011 rd_addr  output  $clog2(K_TILES*SA_DIM): operand buffer read address.
REQ-012 head_idx  output  $clog2(NUM_HEADS): head currently in progress.
REQ-013 out_valid  output  1: accumulator result (4x19-bit, 76 bits, outside this block) is valid for head_idx.
REQ-014 done  output  1: one-cycle pulse at the end of a full pass.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, FEED, FLUSH, DRAIN and DONE.
REQ-016 IDLE -> CLEAR SHALL occur on the first clock edge with start=1; head_idx SHALL be 0 on entering CLEAR from IDLE.
REQ-017 CLEAR SHALL last exactly 1 cycle with sa_clear=1, then go to FEED.
REQ-018 FEED SHALL last K_TILES*SA_DIM cycles with feed_en=1; rd_addr SHALL be 0 in the first FEED cycle and increment by 1 each cycle.
REQ-019 FLUSH SHALL last 2*SA_DIM-2 cycles with feed_en=0 to let skewed partial sums propagate; rd_addr SHALL hold its last value.
REQ-020 DRAIN SHALL assert out_valid and hold it, with head_idx stable, until a cycle where out_valid=1 and out_ready=1.
REQ-021 On the DRAIN handshake: if head_idx==NUM_HEADS-1 the FSM SHALL go to DONE; otherwise head_idx SHALL increment, rd_addr SHALL reset to 0 and the FSM SHALL go to CLEAR.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE; head_idx SHALL return to 0.
REQ-023 start asserted in any state other than IDLE SHALL be ignored and not queued.
REQ-024 start asserted in the DONE cycle SHALL be ignored; start sampled in the following IDLE cycle SHALL be accepted.
REQ-025 Without stalls, each head SHALL take 1+K_TILES*SA_DIM+2*SA_DIM-2+1 cycles (24 with defaults). A full pass SHALL take NUM_HEADS*24+1 cycles from CLEAR entry to done (97 with defaults).
REQ-026 Counters SHALL never wrap. The FEED counter SHALL terminate at K_TILES*SA_DIM-1, the FLUSH counter at 2*SA_DIM-3, and head_idx at NUM_HEADS-1.
REQ-027 sa_clear, feed_en, out_valid and done SHALL be mutually exclusive in every cycle.

Reset
REQ-028 While reset=1: state=IDLE, busy=0, sa_clear=0, feed_en=0, out_valid=0, done=0, rd_addr=0, head_idx=0, independent of clk.
REQ-029 Reset asserted mid-pass (any state) SHALL abort immediately. After release, the block SHALL stay in IDLE until a new start.

Verification
REQ-030 Defaults, start pulse at cycle 0, out_ready tied 1 -> sa_clear at cycle 1; feed_en in cycles 2-17 with rd_addr 0..15; out_valid in cycle 24 with head_idx=0; done in cycle 97; busy=0 at cycle 98.
REQ-031 out_ready held 0 for 5 cycles in head 2 DRAIN -> out_valid stays high with head_idx=2 for 6 cycles; done is delayed by exactly 5 cycles to cycle 102.
REQ-032 start re-pulsed during FEED of head 1 and in the DONE cycle -> no effect; exactly one done per accepted start; start one cycle after done -> new pass begins with head_idx=0.
REQ-033 reset asserted asynchronously (between edges) during FLUSH of head 3 -> all outputs go to reset values before the next edge; no done; a subsequent start gives the nominal 97-cycle pass.
REQ-034 NUM_HEADS=1, K_TILES=1 -> FEED 4 cycles, FLUSH 6 cycles, out_valid at cycle 12, done at cycle 13.
REQ-035 Assertion checks over all runs: REQ-027 exclusivity holds; rd_addr never exceeds K_TILES*SA_DIM-1; head_idx never exceeds NUM_HEADS-1.
